// File: rtl/run_controller.sv
`default_nettype none
// =============================================================================
// Module : run_controller
// Desc   : Loads a program into instruction memory, runs the core from a start
//          PC until an end PC or watchdog limit, and captures the result.
// Rev    : 1.0 - initial release
// =============================================================================
module run_controller #(
    parameter int IMEM_AW      = 6,
    parameter int WATCHDOG_MAX = 255
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [IMEM_AW-1:0] ld_addr,
    input  logic [31:0]        ld_data,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_waddr,
    output logic [31:0]        imem_wdata,
    input  logic               start,
    input  logic [63:0]        start_pc,
    input  logic [63:0]        end_pc,
    output logic               cpu_resetl,
    output logic [63:0]        cpu_startpc,
    input  logic [63:0]        cpu_currentpc,
    input  logic [63:0]        cpu_memtoreg,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [63:0]        result,
    output logic [15:0]        cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RESET0 = 3'd1,
        S_RESET1 = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam logic [16:0] c_wd_max17 = 17'(WATCHDOG_MAX);
    localparam logic [15:0] c_wd_max   = 16'(WATCHDOG_MAX);

    state_t             r_state;
    logic [63:0]        r_end_pc;
    logic               r_imem_we;
    logic [IMEM_AW-1:0] r_imem_waddr;
    logic [31:0]        r_imem_wdata;
    logic               r_cpu_resetl;
    logic [63:0]        r_cpu_startpc;
    logic               r_busy;
    logic               r_done;
    logic               r_timeout;
    logic [63:0]        r_result;
    logic [15:0]        r_cycle_count;

    logic               w_can_start;
    logic [15:0]        w_count_inc;
    logic               w_wd_hit;

    assign w_can_start = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_FAULT);
    // Saturating increment keeps the counter from wrapping on long watchdogs.
    assign w_count_inc = (r_cycle_count == 16'hFFFF) ? r_cycle_count : r_cycle_count + 16'd1;
    assign w_wd_hit    = (({1'b0, r_cycle_count} + 17'd1) == c_wd_max17);

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_end_pc      <= 64'd0;
            r_imem_we     <= 1'b0;
            r_imem_waddr  <= '0;
            r_imem_wdata  <= 32'd0;
            r_cpu_resetl  <= 1'b0;
            r_cpu_startpc <= 64'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_result      <= 64'd0;
            r_cycle_count <= 16'd0;
        end else begin
            r_imem_we <= 1'b0;
            if (w_can_start && start) begin
                r_cpu_startpc <= start_pc;
                r_end_pc      <= end_pc;
                r_cycle_count <= 16'd0;
                r_done        <= 1'b0;
                r_timeout     <= 1'b0;
                r_busy        <= 1'b1;
                r_cpu_resetl  <= 1'b0;
                r_state       <= S_RESET0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (ld_valid) begin
                            r_imem_we    <= 1'b1;
                            r_imem_waddr <= ld_addr;
                            r_imem_wdata <= ld_data;
                        end
                    end
                    S_RESET0: r_state <= S_RESET1;
                    S_RESET1: begin
                        r_cpu_resetl <= 1'b1;
                        r_state      <= S_RUN;
                    end
                    S_RUN: begin
                        // End match outranks the watchdog when both fire together.
                        if (cpu_currentpc >= r_end_pc) begin
                            r_result      <= cpu_memtoreg;
                            r_cycle_count <= w_count_inc;
                            r_done        <= 1'b1;
                            r_busy        <= 1'b0;
                            r_cpu_resetl  <= 1'b0;
                            r_state       <= S_DONE;
                        end else if (w_wd_hit) begin
                            r_cycle_count <= c_wd_max;
                            r_timeout     <= 1'b1;
                            r_busy        <= 1'b0;
                            r_cpu_resetl  <= 1'b0;
                            r_state       <= S_FAULT;
                        end else begin
                            r_cycle_count <= w_count_inc;
                        end
                    end
                    S_DONE, S_FAULT: ;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign ld_ready    = (r_state == S_IDLE) && !start;
    assign imem_we     = r_imem_we;
    assign imem_waddr  = r_imem_waddr;
    assign imem_wdata  = r_imem_wdata;
    assign cpu_resetl  = r_cpu_resetl;
    assign cpu_startpc = r_cpu_startpc;
    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign result      = r_result;
    assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_run_controller.sv
`default_nettype none
// =============================================================================
// Module : tb_run_controller
// Desc   : Directed bench for run_controller with a simple PC+4 core model and
//          a per-cycle reference model of the controller's observable behaviour.
// Rev    : 1.0 - initial release
// =============================================================================
module tb_run_controller;

    localparam int IMEM_AW      = 6;
    localparam int WATCHDOG_MAX = 255;

    logic               CLK = 1'b0;
    logic               reset = 1'b1;
    logic               ld_valid = 1'b0;
    logic               ld_ready;
    logic [IMEM_AW-1:0] ld_addr = '0;
    logic [31:0]        ld_data = 32'd0;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_waddr;
    logic [31:0]        imem_wdata;
    logic               start = 1'b0;
    logic [63:0]        start_pc = 64'd0;
    logic [63:0]        end_pc = 64'd0;
    logic               cpu_resetl;
    logic [63:0]        cpu_startpc;
    logic [63:0]        cpu_currentpc;
    logic [63:0]        cpu_memtoreg;
    logic               busy;
    logic               done;
    logic               timeout;
    logic [63:0]        result;
    logic [15:0]        cycle_count;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    bit pc_stuck = 1'b0;

    always #5 CLK = ~CLK;

    run_controller #(.IMEM_AW(IMEM_AW), .WATCHDOG_MAX(WATCHDOG_MAX)) dut (
        .CLK(CLK), .reset(reset),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .start(start), .start_pc(start_pc), .end_pc(end_pc),
        .cpu_resetl(cpu_resetl), .cpu_startpc(cpu_startpc),
        .cpu_currentpc(cpu_currentpc), .cpu_memtoreg(cpu_memtoreg),
        .busy(busy), .done(done), .timeout(timeout),
        .result(result), .cycle_count(cycle_count)
    );

    // Core model: held at the start PC while in reset, advances by 4 per running cycle.
    logic [63:0] core_pc;
    always @(posedge CLK) begin
        if (!cpu_resetl) core_pc <= cpu_startpc;
        else             core_pc <= core_pc + 64'd4;
    end
    assign cpu_currentpc = pc_stuck ? 64'h10 : core_pc;
    assign cpu_memtoreg  = (cpu_currentpc == 64'h30) ? 64'hF : cpu_currentpc + 64'h1000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model, stepped on every rising edge from the same inputs the DUT sees.
    string       m_where = "IDLE";
    int          m_rst_left = 0;
    logic [63:0] m_startpc = 0, m_endpc = 0, m_result = 0;
    logic [15:0] m_cnt = 0;
    logic        m_done = 0, m_to = 0, m_we = 0;
    logic [IMEM_AW-1:0] m_waddr = 0;
    logic [31:0] m_wdata = 0;

    always @(posedge CLK) begin
        m_we = 1'b0;
        if (reset) begin
            m_where = "IDLE"; m_startpc = 0; m_endpc = 0; m_result = 0;
            m_cnt = 0; m_done = 0; m_to = 0; m_waddr = 0; m_wdata = 0;
        end else if (start && (m_where == "IDLE" || m_where == "DONE" || m_where == "FAULT")) begin
            m_startpc = start_pc; m_endpc = end_pc; m_cnt = 0;
            m_done = 0; m_to = 0; m_where = "RESET"; m_rst_left = 2;
        end else if (m_where == "IDLE" && ld_valid) begin
            m_we = 1'b1; m_waddr = ld_addr; m_wdata = ld_data;
        end else if (m_where == "RESET") begin
            m_rst_left--;
            if (m_rst_left == 0) m_where = "RUN";
        end else if (m_where == "RUN") begin
            if (cpu_currentpc >= m_endpc) begin
                m_result = cpu_memtoreg;
                if (m_cnt != 16'hFFFF) m_cnt++;
                m_done = 1; m_where = "DONE";
            end else if (int'(m_cnt) + 1 == WATCHDOG_MAX) begin
                m_cnt = 16'(WATCHDOG_MAX); m_to = 1; m_where = "FAULT";
            end else if (m_cnt != 16'hFFFF) begin
                m_cnt++;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("ld_ready",    64'(ld_ready),   64'((m_where == "IDLE") && !start));
            chk("imem_we",     64'(imem_we),    64'(m_we));
            chk("imem_waddr",  64'(imem_waddr), 64'(m_waddr));
            chk("imem_wdata",  64'(imem_wdata), 64'(m_wdata));
            chk("cpu_resetl",  64'(cpu_resetl), 64'(m_where == "RUN"));
            chk("cpu_startpc", cpu_startpc,     m_startpc);
            chk("busy",        64'(busy),       64'(m_where == "RESET" || m_where == "RUN"));
            chk("done",        64'(done),       64'(m_done));
            chk("timeout",     64'(timeout),    64'(m_to));
            chk("result",      result,          m_result);
            chk("cycle_count", 64'(cycle_count), 64'(m_cnt));
        end
    end

    int we_count = 0;
    logic [IMEM_AW-1:0] last_waddr;
    logic [31:0] last_wdata;
    always @(negedge CLK) begin
        if (imem_we === 1'b1) begin
            we_count++;
            last_waddr = imem_waddr;
            last_wdata = imem_wdata;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_end(input int budget);
        int k = 0;
        while (!(done || timeout) && k < budget) begin
            tick();
            k++;
        end
        chk("run_finished_in_budget", 64'(done || timeout), 64'd1);
    endtask

    task automatic do_start(input logic [63:0] spc, input logic [63:0] epc);
        start = 1'b1; start_pc = spc; end_pc = epc;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int lo;
        tick(); tick();
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_resetl", 64'(cpu_resetl), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_count",  64'(cycle_count), 64'd0);
        chk("rst_ready",  64'(ld_ready), 64'd1);

        // Single transfer produces exactly one write strobe.
        we_count = 0;
        ld_valid = 1'b1; ld_addr = 6'd5; ld_data = 32'hF8000000;
        tick();
        ld_valid = 1'b0;
        tick(); tick();
        chk("single_we_count", 64'(we_count), 64'd1);
        chk("single_waddr", 64'(last_waddr), 64'd5);
        chk("single_wdata", 64'(last_wdata), 64'hF8000000);

        // Back-to-back program load of 13 words.
        we_count = 0;
        for (int i = 0; i < 13; i++) begin
            ld_valid = 1'b1; ld_addr = 6'(i); ld_data = 32'h1000_0000 + 32'(i * 7);
            tick();
        end
        ld_valid = 1'b0;
        tick();
        chk("load_we_count", 64'(we_count), 64'd13);
        chk("load_last_waddr", 64'(last_waddr), 64'd12);

        // Start together with a loader request: start wins, no write.
        we_count = 0;
        ld_valid = 1'b1; ld_addr = 6'd40; ld_data = 32'hDEADBEEF;
        start = 1'b1; start_pc = 64'd0; end_pc = 64'h30;
        #1;
        chk("start_vs_ld_ready", 64'(ld_ready), 64'd0);
        tick();
        start = 1'b0; ld_valid = 1'b0;
        lo = 0;
        while (!cpu_resetl && lo < 10) begin
            lo++;
            tick();
        end
        chk("reset_low_cycles", 64'(lo), 64'd2);
        chk("run_ld_ready", 64'(ld_ready), 64'd0);
        wait_end(400);
        tick();
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_timeout", 64'(timeout), 64'd0);
        chk("t1_result", result, 64'hF);
        chk("t1_count", 64'(cycle_count), 64'd13);
        chk("t1_no_write", 64'(we_count), 64'd0);

        // Reset during the fifth run cycle.
        do_start(64'd0, 64'h30);
        lo = 0;
        while (!cpu_resetl && lo < 10) begin
            lo++;
            tick();
        end
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_resetl", 64'(cpu_resetl), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_count", 64'(cycle_count), 64'd0);
        chk("midrst_result", result, 64'd0);
        chk("midrst_ready", 64'(ld_ready), 64'd1);

        // Watchdog: core PC stuck below the end address.
        pc_stuck = 1'b1;
        do_start(64'd0, 64'h54);
        wait_end(400);
        chk("wd_timeout", 64'(timeout), 64'd1);
        chk("wd_done", 64'(done), 64'd0);
        chk("wd_count", 64'(cycle_count), 64'd255);
        chk("wd_result", result, 64'd0);
        pc_stuck = 1'b0;

        // End at or below start: finishes on the first run cycle.
        do_start(64'h40, 64'd0);
        wait_end(50);
        chk("short_done", 64'(done), 64'd1);
        chk("short_count", 64'(cycle_count), 64'd1);
        chk("short_result", result, 64'h1040);

        // Restart from DONE.
        do_start(64'h40, 64'h54);
        chk("restart_done_clr", 64'(done), 64'd0);
        wait_end(50);
        chk("restart_done", 64'(done), 64'd1);
        chk("restart_count", 64'(cycle_count), 64'd6);
        chk("restart_result", result, 64'h1054);

        tick(); tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/run_controller.md
# run_controller

Sequencing controller wrapped around the single-cycle processor core. Loads a program into instruction memory through a valid/ready stream, holds the core in reset while a start PC is applied, releases it, and watches the core's current PC until it reaches a programmed end address or a watchdog limit expires. On completion it captures the core's MemtoReg result and run length for the host or bench.

## Interface
- IMEM_AW, 6: instruction-memory word-address width.
- WATCHDOG_MAX, 255: maximum RUN cycles before timeout.
- CLK  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; overrides everything.
- ld_valid  in  1  loader word valid.
- ld_ready  out  1  loader ready; `(state==IDLE) && !start`, combinational.
- ld_addr  in  IMEM_AW  instruction word index.
- ld_data  in  32  instruction word.
- imem_we  out  1  instruction-memory write enable, registered.
- imem_waddr  out  IMEM_AW  registered write address.
- imem_wdata  out  32  registered write data.
- start  in  1  run request; sampled only in IDLE, DONE, FAULT.
- start_pc  in  64  start address, captured on start acceptance.
- end_pc  in  64  end address, captured on start acceptance.
- cpu_resetl  out  1  active-low reset to the core.
- cpu_startpc  out  64  start PC to the core.
- cpu_currentpc  in  64  core current PC.
- cpu_memtoreg  in  64  core MemtoReg output.
- busy  out  1  high in RESET and RUN.
- done  out  1  high in DONE.
- timeout  out  1  high in FAULT.
- result  out  64  captured cpu_memtoreg.
- cycle_count  out  16  RUN cycles elapsed in the current or last run.

## Operation
- States: IDLE, RESET0, RESET1, RUN, DONE, FAULT.
- IDLE: loader handshake is enabled. A transfer occurs on `ld_valid && ld_ready`. The next cycle has imem_we=1, imem_waddr=ld_addr, imem_wdata=ld_data. Otherwise imem_we=0 and addr/data hold their values.
- Start acceptance in IDLE, DONE or FAULT:
  - Captures start_pc into cpu_startpc and end_pc into an internal register.
  - Clears cycle_count, done and timeout. result holds its value.
  - Goes to RESET0.
- start is ignored in RESET0, RESET1 and RUN. ld_ready=0 outside IDLE.
- RESET0 → RESET1 → RUN unconditionally. cpu_resetl=0 in both RESET states.
- RUN: cpu_resetl=1. On each cycle, with priority in this order:
  1. If cpu_currentpc ≥ end_reg (64-bit unsigned): result ← cpu_memtoreg, cycle_count ← cycle_count+1, go to DONE.
  2. Else if cycle_count+1 == WATCHDOG_MAX: cycle_count ← WATCHDOG_MAX, go to FAULT.
  3. Else cycle_count ← cycle_count+1.
- DONE/FAULT: cpu_resetl=0 (core frozen at cpu_startpc). State holds until start or reset.
- cycle_count saturates at 16'hFFFF and never wraps.
- end_pc ≤ start_pc: the run completes in the first RUN cycle with cycle_count=1.

## Timing
- Reset values, taking effect the cycle after reset is sampled high:
  - state=IDLE, cpu_resetl=0, cpu_startpc=0, imem_we=0, imem_waddr=0, imem_wdata=0.
  - busy=0, done=0, timeout=0, result=0, cycle_count=0, end_reg=0.
- Reset mid-run: the core drops to reset the next cycle. No imem write is issued, and the partially loaded program is left as is.
- Load latency: handshake at edge N produces the write strobe during cycle N+1, one cycle wide. Back-to-back transfers give back-to-back writes.
- Start at edge T: RESET0 in cycle T+1, RESET1 in T+2, first RUN cycle T+3 with cpu_resetl=1.
- done/timeout rise in the cycle after the terminating RUN cycle. result is valid in the same cycle as done.
- start and ld_valid in the same IDLE cycle: start wins, no write occurs, and ld_valid must be held by the source.
- End match and watchdog in the same cycle: the end match wins (DONE).

## Test plan
- Load 13 words at addresses 0–12. Start with start_pc=0, end_pc=0x30. Core model: PC+4 per RUN cycle, memtoreg=0xF at PC 0x30 → done=1, result=0xF, cycle_count=13, timeout=0.
- Single transfer ld_addr=5, ld_data=0xF8000000 → exactly one imem_we pulse next cycle with waddr=5 and that data. ld_ready=0 during RUN.
- Core PC stuck at 0x10, end_pc=0x54, WATCHDOG_MAX=255 → timeout=1 after 255 RUN cycles, done=0, cycle_count=255, result unchanged.
- start and ld_valid asserted together in IDLE → ld_ready=0, no imem_we. RESET0 next cycle, cpu_resetl low for exactly 2 cycles.
- Assert reset at RUN cycle 5 → next cycle: IDLE, cpu_resetl=0, busy=0, cycle_count=0, result=0. A following start runs normally.
- start_pc=0x40, end_pc=0 → DONE after 1 RUN cycle, cycle_count=1. A restart from DONE with end_pc=0x54 completes and result updates.
